// File: rtl/lfsr_rr_server_if.sv
// Handshake bundle between the shared-LFSR round-robin server and its requesters.
// The master side drives seeds and requests; the slave side (the server) returns grants and words.
interface lfsr_rr_server_if #(
  parameter int LENGTH = 16,
  parameter int NREQ   = 4
);
  logic [LENGTH-1:0] seed;
  logic              seed_load;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   gnt;
  logic [LENGTH-1:0] data;
  logic              valid;
  logic              wrap;
  logic              seed_err;

  modport master (
    output seed, seed_load, req,
    input  gnt, data, valid, wrap, seed_err
  );

  modport slave (
    input  seed, seed_load, req,
    output gnt, data, valid, wrap, seed_err
  );
endinterface

// File: rtl/lfsr_rr_server.sv
// Round-robin server sharing one Fibonacci LFSR among NREQ requesters: one word per grant,
// one LFSR step per delivered word, with reseed, zero-seed protection and period-wrap flag.
module lfsr_rr_server #(
  parameter int              LENGTH = 16,
  parameter logic [LENGTH-1:0] TAPS = 16'hD008,
  parameter int              NREQ   = 4
) (
  input  logic                clk,
  input  logic                rst,
  lfsr_rr_server_if.slave     bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {ST_SEED, ST_RUN} state_t;

  state_t            state_q;
  logic [LENGTH-1:0] lfsr_q, ref_q, data_q;
  logic [PW-1:0]     ptr_q;
  logic [NREQ-1:0]   gnt_q;
  logic              valid_q, wrap_q, seed_err_q;

  logic [LENGTH-1:0] lfsr_d, seed_safe;
  logic [PW-1:0]     win, cand, ptr_d;
  logic [NREQ-1:0]   gnt_d;
  logic              found;

  function automatic logic [LENGTH-1:0] lfsr_step(input logic [LENGTH-1:0] s);
    return {s[LENGTH-2:0], ^(s & TAPS)};
  endfunction

  assign lfsr_d    = lfsr_step(lfsr_q);
  assign seed_safe = (bus.seed == '0) ? LENGTH'(1) : bus.seed;

  // Search ptr, ptr+1, ... modulo NREQ for the first active request.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = PW'((int'(ptr_q) + i) % NREQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign ptr_d = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
  assign gnt_d = {{(NREQ-1){1'b0}}, 1'b1} << win;

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      lfsr_q     <= LENGTH'(1);
      ref_q      <= LENGTH'(1);
      ptr_q      <= '0;
      gnt_q      <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      wrap_q     <= 1'b0;
      seed_err_q <= 1'b0;
    end else if (bus.seed_load) begin
      // Reseed beats any pending request; the pointer is deliberately kept.
      state_q    <= ST_SEED;
      lfsr_q     <= seed_safe;
      ref_q      <= seed_safe;
      seed_err_q <= (bus.seed == '0);
      gnt_q      <= '0;
      valid_q    <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_SEED: begin
          state_q <= ST_RUN;
          gnt_q   <= '0;
          valid_q <= 1'b0;
          wrap_q  <= 1'b0;
        end
        default: begin
          if (found) begin
            gnt_q   <= gnt_d;
            valid_q <= 1'b1;
            data_q  <= lfsr_q;
            wrap_q  <= (lfsr_d == ref_q);
            lfsr_q  <= lfsr_d;
            ptr_q   <= ptr_d;
          end else begin
            gnt_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.data     = data_q;
  assign bus.valid    = valid_q;
  assign bus.wrap     = wrap_q;
  assign bus.seed_err = seed_err_q;

endmodule

// File: doc/lfsr_rr_server.md
# lfsr_rr_server

Round-robin scheduler that shares one Fibonacci LFSR among NREQ requesters. Each accepted request gets exactly one pseudo-random word, and the LFSR advances once per delivered word, so no two requesters ever receive the same word within a period. The block also handles reseeding, zero-seed protection and period-wrap detection. It sits between the pseudo-random generator and its consumers (scramblers, test-pattern sources).

## Interface
- LENGTH, 16: LFSR word width, ≥ 2.
- TAPS, 53256: feedback tap mask. Bit i set means state bit i enters the feedback XOR.
- NREQ, 4: number of requesters, 2..16.
- clk  in  1: clock, all logic on rising edge.
- rst  in  1: synchronous, active-high reset.
- seed  in  LENGTH: seed value, sampled when seed_load=1.
- seed_load  in  1: reseed command, level-sampled each edge.
- req  in  NREQ: per-requester request, level.
- gnt  out  NREQ: one-hot grant, registered.
- data  out  LENGTH: delivered word, valid while valid=1.
- valid  out  1: gnt/data qualifier, always equals |gnt.
- wrap  out  1: high with the last word of an LFSR period.
- seed_err  out  1: sticky; last seed_load carried seed==0.

## Operation
- Internal registers:
  - lfsr[LENGTH-1:0]: current state.
  - ref[LENGTH-1:0]: value at last (re)seed.
  - ptr: round-robin pointer, 0..NREQ-1.
  - FSM states: SEED, RUN.
- Step function: fb = XOR-reduce(lfsr & TAPS); next = {lfsr[LENGTH-2:0], fb}.
- Reset: lfsr=1, ref=1, ptr=0, FSM=RUN, gnt=0, valid=0, data=0, wrap=0, seed_err=0.
- seed_load=1 at an edge, from any state:
  - lfsr and ref take seed, or 1 if seed==0.
  - seed_err takes (seed==0).
  - FSM goes to SEED. gnt, valid and wrap go to 0 for the next cycle.
  - ptr is unchanged.
  - seed_load has priority over all requests.
- SEED: issues no grant for one cycle, then moves to RUN unless seed_load is still 1. This guarantees one dead cycle after every reseed.
- RUN, with seed_load=0 and req≠0:
  - Winner w is the first set req bit searching ptr, ptr+1, … with wrap-around modulo NREQ.
  - Next edge: gnt=onehot(w), valid=1, data=lfsr, wrap=(next(lfsr)==ref), lfsr=next(lfsr).
  - ptr becomes (w+1) mod NREQ.
- RUN, with req==0: gnt=0, valid=0, wrap=0. lfsr and ptr hold; data holds its last value.
- Back-to-back grants are allowed, one word per cycle. A requester that keeps req high is re-arbitrated every cycle under the round-robin order, so it cannot starve the others.
- A requester wanting a single word deasserts req while it sees its gnt.
- A maximal TAPS gives period 2^LENGTH−1. wrap then pulses on every (2^LENGTH−1)-th word after a seed.
- Zero-lockup protection: the all-zero state can only arise from seed==0, and that case is forced to 1.

## Timing
- Latency: req sampled at edge k drives gnt/data/valid after edge k+1 (1 cycle).
- gnt, data, valid and wrap are all registered and change only on edges.
- Reseed: seed_load at edge k gives a dead cycle after k+1. The first grant after reseed comes at edge k+2 at the earliest, and data equals the seed (or 1 for seed==0).
- Simultaneous seed_load and req: the reseed wins, and the request is served later if still held.
- rst overrides seed_load and req in the same cycle.
- Reset mid-stream: the next cycle shows gnt=0, valid=0, and the sequence restarts from 1.
- seed_err clears only on rst or on a seed_load with a nonzero seed.

## Test plan
- Reset, then req=4'b0001 held with default parameters:
  - data sequence is 0x0001, 0x0002, 0x0004, 0x0008, 0x0011, 0x0022, 0x0044, 0x0088, 0x0111.
  - gnt=4'b0001 every cycle from the second cycle after reset release.
- req=4'b1111 held: gnt cycles 0001→0010→0100→1000→0001. Consecutive data values are successive LFSR steps, with no repeats or gaps.
- req=4'b1010 held, with ptr=0 after reset: grants go 0010, 1000, 0010, … The idle requesters 0 and 2 never receive a grant.
- seed_load=1, seed=0xACE1, together with req=4'b0001 at the same edge:
  - next cycle valid=0.
  - following cycle data=0xACE1.
- seed_load with seed=0: seed_err=1, the first delivered data=0x0001, and no all-zero word ever appears. A later seed_load with seed=0x0005 clears seed_err.
- LENGTH=4, TAPS=4'b1100, req held:
  - wrap pulses on word 15, then on word 30.
  - the 15 delivered words are distinct and nonzero.
  - rst asserted mid-run restarts data at 0x1.
